// File: rtl/jump_decoder_multi_if.sv
// ============================================================================
// jump_decoder_multi_if : fetch-side bundle and decode-result bus for jump_decoder_multi
// Rev 1.0
// ============================================================================
`default_nettype none

interface jump_decoder_multi_if #(
  parameter int LANES     = 2,
  parameter int RAS_DEPTH = 8
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic                  mode64;
  logic                  stall;
  logic                  flush;
  logic [LANES-1:0]      in_valid;
  logic [32*LANES-1:0]   instr;
  logic                  in_ready;
  logic [LANES-1:0]      out_valid;
  logic [LANES-1:0]      isJump;
  logic [5*LANES-1:0]    jumpType;
  logic [LANES-1:0]      jumpIndir;
  logic [LANES-1:0]      isIPRel;
  logic [64*LANES-1:0]   constant;
  logic [LANES-1:0]      pushCallStack;
  logic [LANES-1:0]      popCallStack;
  logic [CW-1:0]         ras_occ;
  logic                  ras_ovf;
  logic                  ras_unf;
`ifdef JUMP_DEC_ERR_EN
  logic [LANES-1:0]      dec_error;
`endif

  modport master (
    output mode64, stall, flush, in_valid, instr,
    input  in_ready, out_valid, isJump, jumpType, jumpIndir, isIPRel, constant,
           pushCallStack, popCallStack, ras_occ, ras_ovf, ras_unf
`ifdef JUMP_DEC_ERR_EN
           , dec_error
`endif
  );

  modport slave (
    input  mode64, stall, flush, in_valid, instr,
    output in_ready, out_valid, isJump, jumpType, jumpIndir, isIPRel, constant,
           pushCallStack, popCallStack, ras_occ, ras_ovf, ras_unf
`ifdef JUMP_DEC_ERR_EN
           , dec_error
`endif
  );
endinterface

`default_nettype wire

// File: rtl/jump_decoder_multi.sv
// ============================================================================
// jump_decoder_multi : registered multi-lane RV jump/branch decoder with
// speculative return-stack occupancy. Optional macro JUMP_DEC_ERR_EN adds dec_error.
// Rev 1.0
// ============================================================================
`default_nettype none

module jump_decoder_multi #(
  parameter int LANES     = 2,
  parameter int RAS_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  jump_decoder_multi_if.slave bus
);
  localparam int            CW        = $clog2(RAS_DEPTH + 1);
  localparam logic [4:0]    JT_UNCOND = 5'b10000;
  localparam logic [CW-1:0] OCC_MAX   = CW'(RAS_DEPTH);
  localparam logic [6:0]    OP_JAL    = 7'b1101111;
  localparam logic [6:0]    OP_JALR   = 7'b1100111;
  localparam logic [6:0]    OP_BR     = 7'b1100011;

  typedef struct packed {
    logic        is_jump;
    logic [4:0]  jtype;
    logic        indir;
    logic        iprel;
    logic [63:0] konst;
    logic        push;
    logic        pop;
`ifdef JUMP_DEC_ERR_EN
    logic        err;
`endif
  } dec_t;

  localparam dec_t DEC_IDLE = '{jtype: JT_UNCOND, default: '0};

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic dec_t decode(input logic [31:0] ins, input logic vld, input logic m64);
    dec_t       d;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       is_jal;
    logic       is_jalr;
    logic       is_br;
    logic [31:0] imm;
    d       = DEC_IDLE;
    f3      = ins[14:12];
    rd      = ins[11:7];
    rs1     = ins[19:15];
    is_jal  = vld && (ins[6:0] == OP_JAL);
    is_jalr = vld && (ins[6:0] == OP_JALR) && (f3 == 3'b000);
    // funct3 010/011 are unassigned branch encodings
    is_br   = vld && (ins[6:0] == OP_BR) && (f3[2:1] != 2'b01);
    imm     = '0;
    if (is_jal) begin
      imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    end else if (is_jalr) begin
      imm = {{20{ins[31]}}, ins[31:20]};
    end else if (is_br) begin
      imm     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      d.jtype = {2'b00, f3};
    end
    d.is_jump = is_jal || is_jalr || is_br;
    d.indir   = is_jalr;
    d.iprel   = is_jal || is_br;
    d.konst   = {(m64 ? {32{imm[31]}} : 32'h0), imm};
    d.push    = (is_jal || is_jalr) && is_link(rd);
    d.pop     = is_jalr && is_link(rs1) && (!is_link(rd) || (rd != rs1));
`ifdef JUMP_DEC_ERR_EN
    d.err     = vld && (((ins[6:0] == OP_BR) && (f3[2:1] == 2'b01)) ||
                        ((ins[6:0] == OP_JALR) && (f3 != 3'b000)));
`endif
    return d;
  endfunction

  dec_t             dec    [LANES];
  dec_t             lane_q [LANES];
  logic [LANES-1:0] lane_vld;
  logic [CW-1:0]    occ_q;
  logic [CW-1:0]    occ_n;
  logic             ovf_q;
  logic             ovf_n;
  logic             unf_q;
  logic             unf_n;

  // A flush presents every lane as invalid, so the registers load idle lanes
  assign lane_vld = bus.in_valid & ~{LANES{bus.flush}};

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      dec[i] = decode(bus.instr[32*i +: 32], lane_vld[i], bus.mode64);
    end
  end

  always_comb begin
    occ_n = occ_q;
    ovf_n = ovf_q;
    unf_n = unf_q;
    for (int i = 0; i < LANES; i++) begin
      if (dec[i].pop) begin
        if (occ_n == '0) unf_n = 1'b1;
        else             occ_n = occ_n - CW'(1);
      end
      if (dec[i].push) begin
        if (occ_n == OCC_MAX) ovf_n = 1'b1;
        else                  occ_n = occ_n + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) lane_q[i] <= DEC_IDLE;
      occ_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.flush || !bus.stall) begin
      for (int i = 0; i < LANES; i++) lane_q[i] <= dec[i];
      occ_q <= bus.flush ? '0 : occ_n;
      ovf_q <= ovf_n;
      unf_q <= unf_n;
    end
  end

  logic [LANES-1:0] valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (bus.flush || !bus.stall) begin
      valid_q <= lane_vld;
    end
  end

  assign bus.in_ready  = ~bus.stall;
  assign bus.out_valid = valid_q;
  assign bus.ras_occ   = occ_q;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      bus.isJump[i]           = lane_q[i].is_jump;
      bus.jumpType[5*i +: 5]  = lane_q[i].jtype;
      bus.jumpIndir[i]        = lane_q[i].indir;
      bus.isIPRel[i]          = lane_q[i].iprel;
      bus.constant[64*i +: 64] = lane_q[i].konst;
      bus.pushCallStack[i]    = lane_q[i].push;
      bus.popCallStack[i]     = lane_q[i].pop;
`ifdef JUMP_DEC_ERR_EN
      bus.dec_error[i]        = lane_q[i].err;
`endif
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_jump_decoder_multi.sv
// ============================================================================
// tb_jump_decoder_multi : directed vector table plus stall/flush/overflow sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_jump_decoder_multi;
  localparam int LANES     = 2;
  localparam int RAS_DEPTH = 8;

  localparam logic        T     = 1'b1;
  localparam logic        F     = 1'b0;
  localparam logic [4:0]  JU    = 5'b10000;
  localparam logic [31:0] JAL1  = 32'h008000EF;
  localparam logic [31:0] RET   = 32'h00008067;
  localparam logic [31:0] BEQM4 = 32'hFE000EE3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jump_decoder_multi_if #(.LANES(LANES), .RAS_DEPTH(RAS_DEPTH)) bus ();

  jump_decoder_multi #(.LANES(LANES), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        m64;
    logic        jump0;
    logic [4:0]  jt0;
    logic        indir0;
    logic        iprel0;
    logic [63:0] c0;
    logic        push0;
    logic        pop0;
    logic        err0;
    logic        jump1;
    logic        push1;
    logic        pop1;
    logic [3:0]  occ;
    logic        unf;
  } vec_t;

  vec_t tbl [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.mode64   = 1'b1;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 2'b11;
    bus.instr    = '0;

    //            vld    i0            i1    m64 jmp0 jt0      ind iprl const0                  psh pop err j1 p1 q1 occ    unf
    tbl[0]  = '{2'b01, RET,          32'h0, T, T, JU,      T, F, 64'h0,                 F, T, F, F, F, F, 4'd0, T};
    tbl[1]  = '{2'b01, JAL1,         32'h0, T, T, JU,      F, T, 64'h8,                 T, F, F, F, F, F, 4'd1, T};
    tbl[2]  = '{2'b01, BEQM4,        32'h0, T, T, 5'b00000, F, T, 64'hFFFFFFFFFFFFFFFC, F, F, F, F, F, F, 4'd1, T};
    tbl[3]  = '{2'b01, BEQM4,        32'h0, F, T, 5'b00000, F, T, 64'h00000000FFFFFFFC, F, F, F, F, F, F, 4'd1, T};
    tbl[4]  = '{2'b01, 32'h000280E7, 32'h0, T, T, JU,      T, F, 64'h0,                 T, T, F, F, F, F, 4'd1, T};
    tbl[5]  = '{2'b01, 32'h000080E7, 32'h0, T, T, JU,      T, F, 64'h0,                 T, F, F, F, F, F, 4'd2, T};
    tbl[6]  = '{2'b01, 32'h00001863, 32'h0, T, T, 5'b00001, F, T, 64'h10,                F, F, F, F, F, F, 4'd2, T};
    tbl[7]  = '{2'b01, 32'h00002063, 32'h0, T, F, JU,      F, F, 64'h0,                 F, F, T, F, F, F, 4'd2, T};
    tbl[8]  = '{2'b01, 32'h00100093, 32'h0, T, F, JU,      F, F, 64'h0,                 F, F, F, F, F, F, 4'd2, T};
    tbl[9]  = '{2'b01, 32'hFFFFF06F, 32'h0, T, T, JU,      F, T, 64'hFFFFFFFFFFFFFFFE, F, F, F, F, F, F, 4'd2, T};
    tbl[10] = '{2'b01, 32'h7FF102E7, 32'h0, F, T, JU,      T, F, 64'h7FF,               T, F, F, F, F, F, 4'd3, T};
    tbl[11] = '{2'b01, 32'h00009067, 32'h0, T, F, JU,      F, F, 64'h0,                 F, F, T, F, F, F, 4'd3, T};
    tbl[12] = '{2'b00, JAL1,         JAL1,  T, F, JU,      F, F, 64'h0,                 F, F, F, F, F, F, 4'd3, T};
    tbl[13] = '{2'b11, RET,          JAL1,  T, T, JU,      T, F, 64'h0,                 F, T, F, T, T, F, 4'd3, T};
    tbl[14] = '{2'b11, JAL1,         RET,   T, T, JU,      F, T, 64'h8,                 T, F, F, T, F, T, 4'd3, T};

    // reset state, held in reset with every lane valid
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_jumpType",  64'(bus.jumpType),  64'h210);
    chk("rst_ras_occ",   64'(bus.ras_occ),   64'h0);
    chk("rst_flags",     64'({bus.ras_ovf, bus.ras_unf}), 64'h0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      bus.in_valid = tbl[i].vld;
      bus.instr    = {tbl[i].i1, tbl[i].i0};
      bus.mode64   = tbl[i].m64;
      tick();
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].vld));
      chk($sformatf("v%0d_isJump0", i),   64'(bus.isJump[0]), 64'(tbl[i].jump0));
      chk($sformatf("v%0d_jumpType0", i), 64'(bus.jumpType[4:0]), 64'(tbl[i].jt0));
      chk($sformatf("v%0d_indir0", i),    64'(bus.jumpIndir[0]), 64'(tbl[i].indir0));
      chk($sformatf("v%0d_iprel0", i),    64'(bus.isIPRel[0]), 64'(tbl[i].iprel0));
      chk($sformatf("v%0d_const0", i),    bus.constant[63:0], tbl[i].c0);
      chk($sformatf("v%0d_push0", i),     64'(bus.pushCallStack[0]), 64'(tbl[i].push0));
      chk($sformatf("v%0d_pop0", i),      64'(bus.popCallStack[0]), 64'(tbl[i].pop0));
      chk($sformatf("v%0d_isJump1", i),   64'(bus.isJump[1]), 64'(tbl[i].jump1));
      chk($sformatf("v%0d_push1", i),     64'(bus.pushCallStack[1]), 64'(tbl[i].push1));
      chk($sformatf("v%0d_pop1", i),      64'(bus.popCallStack[1]), 64'(tbl[i].pop1));
      chk($sformatf("v%0d_ras_occ", i),   64'(bus.ras_occ), 64'(tbl[i].occ));
      chk($sformatf("v%0d_ras_unf", i),   64'(bus.ras_unf), 64'(tbl[i].unf));
      chk($sformatf("v%0d_ras_ovf", i),   64'(bus.ras_ovf), 64'h0);
`ifdef JUMP_DEC_ERR_EN
      chk($sformatf("v%0d_dec_error0", i), 64'(bus.dec_error[0]), 64'(tbl[i].err0));
`endif
    end

    // flush clears occupancy and valids, keeps the sticky underflow
    bus.flush    = 1'b1;
    bus.in_valid = 2'b11;
    bus.instr    = {JAL1, JAL1};
    bus.mode64   = 1'b1;
    tick();
    chk("flush1_out_valid", 64'(bus.out_valid), 64'h0);
    chk("flush1_ras_occ",   64'(bus.ras_occ), 64'h0);
    chk("flush1_ras_unf",   64'(bus.ras_unf), 64'h1);
    bus.flush = 1'b0;

    // two calls per bundle held by stall for three cycles
    bus.stall = 1'b1;
    #1;
    chk("stall_in_ready", 64'(bus.in_ready), 64'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall%0d_out_valid", c), 64'(bus.out_valid), 64'h0);
      chk($sformatf("stall%0d_ras_occ", c),   64'(bus.ras_occ), 64'h0);
    end
    bus.stall = 1'b0;
    #1;
    chk("accept_in_ready", 64'(bus.in_ready), 64'h1);
    for (int b = 1; b <= 5; b++) begin
      tick();
      chk($sformatf("acc%0d_out_valid", b), 64'(bus.out_valid), 64'h3);
      chk($sformatf("acc%0d_push", b),      64'(bus.pushCallStack), 64'h3);
      chk($sformatf("acc%0d_ras_occ", b),   64'(bus.ras_occ), (b < 4) ? 64'(2 * b) : 64'h8);
      chk($sformatf("acc%0d_ras_ovf", b),   64'(bus.ras_ovf), (b == 5) ? 64'h1 : 64'h0);
    end

    // stall holds outputs even when the offered bundle changes
    bus.stall    = 1'b1;
    bus.instr    = {RET, RET};
    bus.in_valid = 2'b01;
    tick();
    tick();
    chk("hold_out_valid", 64'(bus.out_valid), 64'h3);
    chk("hold_push",      64'(bus.pushCallStack), 64'h3);
    chk("hold_pop",       64'(bus.popCallStack), 64'h0);
    chk("hold_ras_occ",   64'(bus.ras_occ), 64'h8);

    // flush wins over stall
    bus.flush = 1'b1;
    tick();
    chk("flush2_out_valid", 64'(bus.out_valid), 64'h0);
    chk("flush2_ras_occ",   64'(bus.ras_occ), 64'h0);
    chk("flush2_ras_ovf",   64'(bus.ras_ovf), 64'h1);
    chk("flush2_ras_unf",   64'(bus.ras_unf), 64'h1);
    chk("flush2_jumpType",  64'(bus.jumpType), 64'h210);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // asynchronous reset is the only way to clear the sticky flags
    #2;
    rst = 1'b0;
    #1;
    chk("arst_flags", 64'({bus.ras_ovf, bus.ras_unf}), 64'h0);
    chk("arst_occ",   64'(bus.ras_occ), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
